axi_lite_regfile: RTL and testbench
===================================

Name: axi_lite_regfile

Overview:
- AXI4-Lite memory-mapped slave register block that sits directly downstream of the interconnect's master port.
- It holds two read/write control registers and two read-only status registers in a 16-byte window at BASE_ADDR.
- The interconnect instantiates one per slave region: BASE_ADDR 0x00 for slave 1, 0x10 for slave 2.
- Control values are also driven out as ports for the datapath.

Parameters:
- DATA_WIDTH, 32, data bus and register width (multiple of 8).
- ADDR_WIDTH, 8, byte-address width.
- BASE_ADDR, 0, window base, 16-byte aligned.

Ports:
- s_axi_aclk  in  1  single clock, all logic rising-edge.
- s_axi_aresetn  in  1  asynchronous active-low reset.
- s_axi_awaddr  in  ADDR_WIDTH  write address.
- s_axi_awvalid  in  1 / s_axi_awready  out  1  write-address handshake.
- s_axi_wdata  in  DATA_WIDTH  write data.
- s_axi_wstrb  in  DATA_WIDTH/8  byte enables.
- s_axi_wvalid  in  1 / s_axi_wready  out  1  write-data handshake.
- s_axi_bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- s_axi_bvalid  out  1 / s_axi_bready  in  1  write-response handshake.
- s_axi_araddr  in  ADDR_WIDTH  read address.
- s_axi_arvalid  in  1 / s_axi_arready  out  1  read-address handshake.
- s_axi_rdata  out  DATA_WIDTH  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid  out  1 / s_axi_rready  in  1  read-data handshake.
- ctrl0_o  out  DATA_WIDTH  current CTRL0.
- ctrl1_o  out  DATA_WIDTH  current CTRL1.

Behaviour:
- Register map (offset = addr - BASE_ADDR):
  - 0x0 CTRL0, RW.
  - 0x4 CTRL1, RW.
  - 0x8 SUM, RO: (CTRL0 + CTRL1) mod 2^DATA_WIDTH, combinational from the registers.
  - 0xC WCOUNT, RO: count of OKAY writes, wraps from all-ones to 0.
- Decode errors (SLVERR):
  - address outside [BASE_ADDR, BASE_ADDR+15];
  - addr[1:0] != 0;
  - any write to 0x8 or 0xC.
- Reset (async assert, sync-release use):
  - CTRL0, CTRL1, WCOUNT = 0.
  - bvalid, rvalid, awready, wready, arready = 0.
  - bresp, rresp = 00; rdata = 0.
  - Write FSM goes to WR_COLLECT; held-address and held-data flags cleared.
  - Reset mid-transaction drops the transaction silently.
- Write FSM:
  - WR_COLLECT:
    - awready = !aw_held; wready = !w_held. AW and W are accepted independently, in either order or the same cycle.
    - Each handshake latches addr, or data+strb, and sets its held flag.
    - Go to WR_COMMIT on the edge at which both are held.
  - WR_COMMIT (one cycle, awready = wready = 0):
    - If decode is OK: update the target register byte-wise, where strb[i] = 1 writes byte i and other bytes are kept. Increment WCOUNT, even if strb = 0. bresp <= 00.
    - If decode errors: no state change, WCOUNT unchanged, bresp <= 10.
    - bvalid <= 1; go to WR_RESP.
  - WR_RESP: hold bvalid and bresp until bvalid && bready. On that edge: bvalid <= 0, clear held flags, go to WR_COLLECT.
  - Latency: AW and W both on edge N, then commit on edge N+1, then bvalid high from N+1. At most one write is outstanding.
- Read path:
  - arready = !rvalid.
  - On arvalid && arready: rdata and rresp are registered the same edge and rvalid <= 1, giving one-cycle latency.
  - Error reads return rdata = 0, rresp = 10.
  - rdata, rresp and rvalid are held stable until rvalid && rready, then rvalid <= 0.
  - A new AR can be accepted no earlier than the cycle after rvalid drops.
- Simultaneous events:
  - A read sampled on the same edge as WR_COMMIT returns the pre-write value, including SUM and WCOUNT.
  - Read and write paths are fully independent; neither stalls the other.
- ctrl0_o and ctrl1_o equal the registers directly and update on the commit edge.

Test Plan:
- Reset, then write 0x11223344 to BASE+0x0 with strb 1111, then read 0x0 → bresp 00, rdata 0x11223344, WCOUNT read at 0xC = 1, ctrl0_o = 0x11223344.
- CTRL0 = 0xFFFFFFFF, CTRL1 = 0x00000002, read 0x8 → rdata 0x00000001, wraparound checked. Partial write 0xAABBCCDD with strb 0101 to CTRL1 → CTRL1 = 0x00BB00DD.
- W presented 3 cycles before AW, and separately AW before W, with bready held low 4 cycles → single commit per transaction, bvalid stable until bready, no second AW/W accepted meanwhile.
- Write to 0x8, then to BASE+0x20 (unmapped), then to 0x2 (unaligned) → each bresp 10, registers and WCOUNT unchanged. Read of 0x20 → rresp 10, rdata 0.
- Read of 0x4 issued on the CTRL1 commit edge, with rready held low 3 cycles → old CTRL1 returned and held stable. A follow-up read returns the new value.
- Assert s_axi_aresetn mid-write while in WR_RESP, then release → bvalid drops immediately, all registers 0, next write completes normally with WCOUNT = 1.

Source files
------------

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave with two RW control registers and two RO status registers
// (SUM, WCOUNT) in a 16-byte window at BASE_ADDR.
module axi_lite_regfile #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [DATA_WIDTH-1:0]   ctrl0_o,
    output logic [DATA_WIDTH-1:0]   ctrl1_o
);

    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {WR_COLLECT, WR_COMMIT, WR_RESP} wr_state_t;

    wr_state_t               wr_state, wr_state_n;
    logic                    aw_held, aw_held_n, w_held, w_held_n;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [STRB_W-1:0]       w_strb;
    logic [DATA_WIDTH-1:0]   ctrl0, ctrl1, wcount, sum, rd_val;
    logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs, rvalid_n;
    logic [2:0]              wr_dec, rd_dec;
    logic                    wr_ok;

    // {valid, register index}: valid means in-window and word-aligned
    function automatic logic [2:0] decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH:0] a, lo, hi;
        logic [1:0]          idx;
        a   = {1'b0, addr};
        lo  = {1'b0, BASE_ADDR};
        hi  = lo + (ADDR_WIDTH+1)'(15);
        idx = 2'((addr - BASE_ADDR) >> 2);
        return {(a >= lo) && (a <= hi) && (addr[1:0] == 2'b00), idx};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                    input logic [DATA_WIDTH-1:0] data,
                                                    input logic [STRB_W-1:0]     strb);
        logic [DATA_WIDTH-1:0] r;
        r = old;
        for (int i = 0; i < STRB_W; i++)
            if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign b_hs   = s_axi_bvalid && s_axi_bready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign r_hs   = s_axi_rvalid && s_axi_rready;
    assign sum    = ctrl0 + ctrl1;
    assign wr_dec = decode(aw_addr);
    assign rd_dec = decode(s_axi_araddr);
    assign wr_ok  = wr_dec[2] && !wr_dec[1];
    assign ctrl0_o = ctrl0;
    assign ctrl1_o = ctrl1;

    always_comb begin
        rd_val = '0;
        case (rd_dec[1:0])
            2'd0:    rd_val = ctrl0;
            2'd1:    rd_val = ctrl1;
            2'd2:    rd_val = sum;
            default: rd_val = wcount;
        endcase
    end

    always_comb begin
        wr_state_n = wr_state;
        aw_held_n  = aw_held;
        w_held_n   = w_held;
        rvalid_n   = ar_hs ? 1'b1 : (r_hs ? 1'b0 : s_axi_rvalid);
        case (wr_state)
            WR_COLLECT: begin
                if (aw_hs) aw_held_n = 1'b1;
                if (w_hs)  w_held_n  = 1'b1;
                if (aw_held_n && w_held_n) wr_state_n = WR_COMMIT;
            end
            WR_COMMIT: wr_state_n = WR_RESP;
            WR_RESP: begin
                if (b_hs) begin
                    wr_state_n = WR_COLLECT;
                    aw_held_n  = 1'b0;
                    w_held_n   = 1'b0;
                end
            end
            default: wr_state_n = WR_COLLECT;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_state      <= WR_COLLECT;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_addr       <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            ctrl0         <= '0;
            ctrl1         <= '0;
            wcount        <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= 2'b00;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rresp   <= 2'b00;
            s_axi_rdata   <= '0;
        end else begin
            wr_state      <= wr_state_n;
            aw_held       <= aw_held_n;
            w_held        <= w_held_n;
            // Ready flags are registered from next state so they never glitch high in reset
            s_axi_awready <= (wr_state_n == WR_COLLECT) && !aw_held_n;
            s_axi_wready  <= (wr_state_n == WR_COLLECT) && !w_held_n;
            s_axi_arready <= !rvalid_n;
            s_axi_rvalid  <= rvalid_n;
            if (aw_hs) aw_addr <= s_axi_awaddr;
            if (w_hs) begin
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            if (wr_state == WR_COMMIT) begin
                if (wr_ok) begin
                    if (wr_dec[0]) ctrl1 <= merge(ctrl1, w_data, w_strb);
                    else           ctrl0 <= merge(ctrl0, w_data, w_strb);
                    wcount      <= wcount + DATA_WIDTH'(1);
                    s_axi_bresp <= 2'b00;
                end else begin
                    s_axi_bresp <= 2'b10;
                end
                s_axi_bvalid <= 1'b1;
            end else if (b_hs) begin
                s_axi_bvalid <= 1'b0;
            end
            // Reads see pre-commit register values on a shared edge
            if (ar_hs) begin
                s_axi_rdata <= rd_dec[2] ? rd_val : '0;
                s_axi_rresp <= rd_dec[2] ? 2'b00 : 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed table-driven bench for axi_lite_regfile plus hand-written
// handshake-ordering, read/commit collision and mid-transaction reset sequences.
module tb_axi_lite_regfile;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata, ctrl0, ctrl1;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;
    int aw_fires = 0;
    int w_fires = 0;

    always #5 clk = ~clk;

    axi_lite_regfile dut (
        .s_axi_aclk   (clk),     .s_axi_aresetn(aresetn),
        .s_axi_awaddr (awaddr),  .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata  (wdata),   .s_axi_wstrb  (wstrb),
        .s_axi_wvalid (wvalid),  .s_axi_wready (wready),
        .s_axi_bresp  (bresp),   .s_axi_bvalid (bvalid),  .s_axi_bready (bready),
        .s_axi_araddr (araddr),  .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata  (rdata),   .s_axi_rresp  (rresp),
        .s_axi_rvalid (rvalid),  .s_axi_rready (rready),
        .ctrl0_o      (ctrl0),   .ctrl1_o      (ctrl1)
    );

    always @(posedge clk) begin
        if (awvalid && awready) aw_fires++;
        if (wvalid && wready)   w_fires++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_done, w_done, aw_fire, w_fire, got;
        resp = 2'bxx;
        @(negedge clk);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
        aw_done = 0; w_done = 0;
        for (int i = 0; i < 50 && !(aw_done && w_done); i++) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(negedge clk);
            if (aw_fire) begin awvalid = 1'b0; aw_done = 1; end
            if (w_fire)  begin wvalid  = 1'b0; w_done  = 1; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        chk("wr_addr_data_accept", {30'd0, aw_done, w_done}, 32'd3);
        bready = 1'b1; got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (bvalid) begin got = 1; resp = bresp; end
            @(negedge clk);
        end
        bready = 1'b0;
        chk("wr_resp_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit ar_done, ar_fire, got;
        d = 'x; resp = 2'bxx;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; ar_done = 0;
        for (int i = 0; i < 50 && !ar_done; i++) begin
            ar_fire = arready;
            @(negedge clk);
            if (ar_fire) ar_done = 1;
        end
        arvalid = 1'b0;
        chk("rd_addr_accept", {31'd0, ar_done}, 32'd1);
        rready = 1'b1; got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (rvalid) begin got = 1; d = rdata; resp = rresp; end
            @(negedge clk);
        end
        rready = 1'b0;
        chk("rd_data_seen", {31'd0, got}, 32'd1);
    endtask

    // One write with W and AW offset by three cycles and bready held low four cycles
    task automatic corner_write(input bit w_first, input logic [7:0] a, input logic [31:0] d);
        int  aw0, w0;
        bit  seen;
        aw0 = aw_fires; w0 = w_fires;
        @(negedge clk);
        if (w_first) begin wvalid = 1'b1; wdata = d; wstrb = 4'hF; end
        else         begin awvalid = 1'b1; awaddr = a; end
        repeat (3) @(negedge clk);
        awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = 4'hF;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bvalid;
        end
        chk("corner_bvalid_seen", {31'd0, seen}, 32'd1);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("corner_bvalid_hold", {31'd0, bvalid}, 32'd1);
            chk("corner_bresp_hold", {30'd0, bresp}, 32'd0);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("corner_bvalid_drop", {31'd0, bvalid}, 32'd0);
        chk("corner_aw_single", aw_fires - aw0, 32'd1);
        chk("corner_w_single", w_fires - w0, 32'd1);
    endtask

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t        vecs[20];
    logic [31:0] rd;
    logic [1:0]  rsp;
    bit          seen;

    initial begin
        vecs[0]  = '{1'b1, 8'h00, 32'h11223344, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 8'h00, 32'h0,        4'h0, 2'b00, 32'h11223344};
        vecs[2]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 2'b00, 32'h00000001};
        vecs[3]  = '{1'b1, 8'h00, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h0};
        vecs[4]  = '{1'b1, 8'h04, 32'h00000002, 4'hF, 2'b00, 32'h0};
        vecs[5]  = '{1'b0, 8'h08, 32'h0,        4'h0, 2'b00, 32'h00000001};
        vecs[6]  = '{1'b1, 8'h04, 32'hAABBCCDD, 4'h5, 2'b00, 32'h0};
        vecs[7]  = '{1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'h00BB00DD};
        vecs[8]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 2'b00, 32'h00000004};
        vecs[9]  = '{1'b1, 8'h08, 32'h12345678, 4'hF, 2'b10, 32'h0};
        vecs[10] = '{1'b1, 8'h20, 32'h12345678, 4'hF, 2'b10, 32'h0};
        vecs[11] = '{1'b1, 8'h02, 32'h12345678, 4'hF, 2'b10, 32'h0};
        vecs[12] = '{1'b0, 8'h0C, 32'h0,        4'h0, 2'b00, 32'h00000004};
        vecs[13] = '{1'b0, 8'h20, 32'h0,        4'h0, 2'b10, 32'h00000000};
        vecs[14] = '{1'b0, 8'h00, 32'h0,        4'h0, 2'b00, 32'hFFFFFFFF};
        vecs[15] = '{1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'h00BB00DD};
        vecs[16] = '{1'b1, 8'h04, 32'h12345678, 4'h0, 2'b00, 32'h0};
        vecs[17] = '{1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'h00BB00DD};
        vecs[18] = '{1'b0, 8'h0C, 32'h0,        4'h0, 2'b00, 32'h00000005};
        vecs[19] = '{1'b0, 8'h03, 32'h0,        4'h0, 2'b10, 32'h00000000};

        aresetn = 1'b0;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        repeat (3) @(negedge clk);
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_wready",  {31'd0, wready},  32'd0);
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
        chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
        chk("rst_rdata",   rdata, 32'd0);
        chk("rst_ctrl0",   ctrl0, 32'd0);
        chk("rst_ctrl1",   ctrl1, 32'd0);
        aresetn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rsp);
                chk($sformatf("vec%0d_bresp", i), {30'd0, rsp}, {30'd0, vecs[i].resp});
                if (i == 0) chk("vec0_ctrl0_o", ctrl0, 32'h11223344);
            end else begin
                axi_read(vecs[i].addr, rd, rsp);
                chk($sformatf("vec%0d_rresp", i), {30'd0, rsp}, {30'd0, vecs[i].resp});
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            end
        end
        chk("tbl_ctrl0_o", ctrl0, 32'hFFFFFFFF);
        chk("tbl_ctrl1_o", ctrl1, 32'h00BB00DD);

        corner_write(1'b1, 8'h00, 32'h00000055);
        chk("wfirst_ctrl0_o", ctrl0, 32'h00000055);
        corner_write(1'b0, 8'h04, 32'h00000066);
        chk("awfirst_ctrl1_o", ctrl1, 32'h00000066);

        // AR lands on the same edge as the CTRL1 commit
        @(negedge clk);
        awaddr = 8'h04; awvalid = 1'b1; wdata = 32'h00000077; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("coll_arready", {31'd0, arready}, 32'd1);
        araddr = 8'h04; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        chk("coll_commit_bvalid", {31'd0, bvalid}, 32'd1);
        chk("coll_ctrl1_new", ctrl1, 32'h00000077);
        for (int i = 0; i < 3; i++) begin
            chk("coll_rvalid_hold", {31'd0, rvalid}, 32'd1);
            chk("coll_rdata_old", rdata, 32'h00000066);
            @(negedge clk);
        end
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        chk("coll_rvalid_drop", {31'd0, rvalid}, 32'd0);
        axi_read(8'h04, rd, rsp);
        chk("coll_followup", rd, 32'h00000077);
        axi_read(8'h0C, rd, rsp);
        chk("wcount_after_corners", rd, 32'd8);
        axi_read(8'h08, rd, rsp);
        chk("sum_after_corners", rd, 32'h000000CC);

        // Reset while the write sits in WR_RESP
        @(negedge clk);
        awaddr = 8'h00; awvalid = 1'b1; wdata = 32'h99; wstrb = 4'hF; wvalid = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            awvalid = 1'b0; wvalid = 1'b0;
            seen = bvalid;
        end
        chk("mid_rst_bvalid_before", {31'd0, seen}, 32'd1);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("mid_rst_ctrl0", ctrl0, 32'd0);
        chk("mid_rst_ctrl1", ctrl1, 32'd0);
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        repeat (2) @(negedge clk);
        axi_read(8'h0C, rd, rsp);
        chk("post_rst_wcount0", rd, 32'd0);
        axi_write(8'h00, 32'h0000005A, 4'hF, rsp);
        chk("post_rst_bresp", {30'd0, rsp}, 32'd0);
        axi_read(8'h0C, rd, rsp);
        chk("post_rst_wcount1", rd, 32'd1);
        axi_read(8'h00, rd, rsp);
        chk("post_rst_ctrl0", rd, 32'h0000005A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
